gain_ramp_control: RTL and testbench

- Parametrised per-band gain stage for the equalizer, successor to the fixed 3-band gain stage.
- Sits between the band-split filter bank and the band summer.
- Applies a signed fixed-point gain per band, with round-to-nearest and saturation.
- Ramps each band's gain toward a written target by a bounded step per sample, which avoids zipper noise. Gains are written one band at a time from the control side.

---
 rtl/eq_pkg.sv | 45 ++++
 rtl/gain_ramp_lane.sv | 70 +++++++
 rtl/gain_ramp_control.sv | 65 ++++++
 tb/tb_gain_ramp_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared defaults and fixed-point helpers for the equalizer gain stage.
// Gains are signed Q(GAIN_W-GAIN_FRAC).GAIN_FRAC; samples are signed DATA_W.
package eq_pkg;

  localparam int EQ_NUM_BANDS = 3;
  localparam int EQ_DATA_W    = 16;
  localparam int EQ_GAIN_W    = 8;
  localparam int EQ_GAIN_FRAC = 4;
  localparam int EQ_RAMP_STEP = 1;

  // Working width for rounding; products must fit (DATA_W+GAIN_W <= SR_W).
  localparam int SR_W = 64;
  localparam logic signed [SR_W-1:0] SR_ONE = 64'sd1;

  typedef struct packed {
    logic                   sat;
    logic signed [SR_W-1:0] val;
  } sat_res_t;

  function automatic int unity_gain(input int frac);
    return 1 << frac;
  endfunction

  // Round half toward +inf, then clamp to a dw-bit signed range.
  function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] p,
                                         input int frac, input int dw);
    sat_res_t res;
    logic signed [SR_W-1:0] half, r, hi, lo;
    half = (frac > 0) ? (SR_ONE <<< (frac - 1)) : '0;
    r    = (p + half) >>> frac;
    hi   = (SR_ONE <<< (dw - 1)) - SR_ONE;
    lo   = -(SR_ONE <<< (dw - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/gain_ramp_lane.sv
// One band: current/target gain with sample-paced ramp, S1 multiply,
// S2 round/saturate and a sticky saturation flag.
module gain_ramp_lane
  import eq_pkg::*;
#(
  parameter int DATA_W    = EQ_DATA_W,
  parameter int GAIN_W    = EQ_GAIN_W,
  parameter int GAIN_FRAC = EQ_GAIN_FRAC,
  parameter int RAMP_STEP = EQ_RAMP_STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_accept,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_wr,
  input  logic                     i_bypass,
  input  logic signed [GAIN_W-1:0] i_wr_data,
  input  logic                     i_s2_en,
  input  logic                     i_sat_clr,
  output logic signed [DATA_W-1:0] o_out,
  output logic                     o_done,
  output logic                     o_sat
);

  localparam int PW = DATA_W + GAIN_W;
  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

  logic signed [GAIN_W-1:0] r_cur, r_target, w_step;
  logic signed [PW-1:0]     r_prod;
  int                       w_diff;
  sat_res_t                 w_res;
  logic                     w_unused_hi;

  always_comb begin
    w_diff = int'(r_target) - int'(r_cur);
    w_step = r_target;
    if (w_diff > RAMP_STEP)       w_step = r_cur + GAIN_W'(RAMP_STEP);
    else if (w_diff < -RAMP_STEP) w_step = r_cur - GAIN_W'(RAMP_STEP);
  end

  assign w_res       = sat_round(SR_W'(r_prod), GAIN_FRAC, DATA_W);
  assign w_unused_hi = ^w_res.val[SR_W-1:DATA_W];
  assign o_done      = (r_cur == r_target);

  // Stepping sees the pre-write target; a bypass write overrides the step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur    <= UNITY;
      r_target <= UNITY;
    end else begin
      if (i_wr) r_target <= i_wr_data;
      if (i_wr && i_bypass) r_cur <= i_wr_data;
      else if (i_accept)    r_cur <= w_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod <= '0;
      o_out  <= '0;
      o_sat  <= 1'b0;
    end else begin
      if (i_accept) r_prod <= i_sample * r_cur;
      if (i_s2_en)  o_out  <= w_res.val[DATA_W-1:0];
      if (i_s2_en && w_res.sat) o_sat <= 1'b1;
      else if (i_sat_clr)       o_sat <= 1'b0;
    end
  end

endmodule

// File: rtl/gain_ramp_control.sv
// Per-band ramped gain stage between the filter bank and the band summer.
// Top holds the valid pipeline, gain write decode and lane array.
module gain_ramp_control
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = EQ_NUM_BANDS,
  parameter int DATA_W    = EQ_DATA_W,
  parameter int GAIN_W    = EQ_GAIN_W,
  parameter int GAIN_FRAC = EQ_GAIN_FRAC,
  parameter int RAMP_STEP = EQ_RAMP_STEP
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [NUM_BANDS-1:0][DATA_W-1:0]      band_in,
  input  logic                                  gain_wr,
  input  logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] gain_wr_sel,
  input  logic signed [GAIN_W-1:0]              gain_wr_data,
  input  logic                                  ramp_bypass,
  input  logic                                  sat_clr,
  output logic                                  out_valid,
  output logic [NUM_BANDS-1:0][DATA_W-1:0]      band_out,
  output logic [NUM_BANDS-1:0]                  ramp_done,
  output logic [NUM_BANDS-1:0]                  sat_flag
);

  localparam int SEL_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int STAGES = 2;

  logic [STAGES-1:0]    r_vld_pipe;
  logic [NUM_BANDS-1:0] w_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[STAGES-2:0], in_valid};
  end

  assign out_valid = r_vld_pipe[STAGES-1];

  // Out-of-range selects match no lane, so the write is dropped.
  for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_lane
    assign w_wr[gi] = gain_wr && (gain_wr_sel == SEL_W'(gi));

    gain_ramp_lane #(
      .DATA_W   (DATA_W),
      .GAIN_W   (GAIN_W),
      .GAIN_FRAC(GAIN_FRAC),
      .RAMP_STEP(RAMP_STEP)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_accept (in_valid),
      .i_sample (band_in[gi]),
      .i_wr     (w_wr[gi]),
      .i_bypass (ramp_bypass),
      .i_wr_data(gain_wr_data),
      .i_s2_en  (r_vld_pipe[0]),
      .i_sat_clr(sat_clr),
      .o_out    (band_out[gi]),
      .o_done   (ramp_done[gi]),
      .o_sat    (sat_flag[gi])
    );
  end

endmodule

// File: tb/tb_gain_ramp_control.sv
// Directed bench for gain_ramp_control with default parameters (unity = 16).
module tb_gain_ramp_control;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [2:0][15:0]  band_in;
  logic              gain_wr;
  logic [1:0]        gain_wr_sel;
  logic signed [7:0] gain_wr_data;
  logic              ramp_bypass;
  logic              sat_clr;
  logic              out_valid;
  logic [2:0][15:0]  band_out;
  logic [2:0]        ramp_done;
  logic [2:0]        sat_flag;

  int checks = 0;
  int errors = 0;

  gain_ramp_control dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .band_in     (band_in),
    .gain_wr     (gain_wr),
    .gain_wr_sel (gain_wr_sel),
    .gain_wr_data(gain_wr_data),
    .ramp_bypass (ramp_bypass),
    .sat_clr     (sat_clr),
    .out_valid   (out_valid),
    .band_out    (band_out),
    .ramp_done   (ramp_done),
    .sat_flag    (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c);
    band_in[0] = 16'(a);
    band_in[1] = 16'(b);
    band_in[2] = 16'(c);
  endtask

  task automatic wr_gain(input int sel, input int g, input logic byp);
    gain_wr      = 1'b1;
    gain_wr_sel  = 2'(sel);
    gain_wr_data = 8'(g);
    ramp_bypass  = byp;
    tick();
    gain_wr     = 1'b0;
    ramp_bypass = 1'b0;
  endtask

  int exp4 [6]  = '{160, 170, 180, 190, 200, 200};
  int exp5 [13] = '{200, 160, 160, 170, 170, 180, 180, 190, 190, 200, 200, 200, 200};

  initial begin
    reset = 1'b0; in_valid = 1'b0; gain_wr = 1'b0; gain_wr_sel = '0;
    gain_wr_data = '0; ramp_bypass = 1'b0; sat_clr = 1'b0;
    set_in(0, 0, 0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_band_out0", $signed(band_out[0]), 0);
    chk("rst_ramp_done", ramp_done, 3'b111);
    chk("rst_sat_flag",  sat_flag,  3'b000);
    reset = 1'b1;
    tick();

    // 1: unity passthrough, two-cycle latency
    in_valid = 1'b1; set_in(1000, -1000, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_latency_ov", out_valid, 0);
    tick();
    chk("t1_ov",  out_valid, 1);
    chk("t1_b0",  $signed(band_out[0]), 1000);
    chk("t1_b1",  $signed(band_out[1]), -1000);
    chk("t1_b2",  $signed(band_out[2]), 0);
    chk("t1_rd",  ramp_done, 3'b111);
    chk("t1_sat", sat_flag, 3'b000);
    tick();
    chk("t1_ov_drop", out_valid, 0);
    chk("t1_hold", $signed(band_out[0]), 1000);

    // 2: saturation both ways; sat_clr loses to a same-edge saturation
    set_in(0, 0, 0);
    wr_gain(0, 127, 1'b1);
    chk("t2_rd_bypass", ramp_done, 3'b111);
    in_valid = 1'b1; set_in(32767, 0, 0);
    tick();
    set_in(-32768, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("t2_pos_clamp", $signed(band_out[0]), 32767);
    chk("t2_sat_set", sat_flag, 3'b001);
    sat_clr = 1'b1;
    tick();
    chk("t2_neg_clamp", $signed(band_out[0]), -32768);
    chk("t2_sat_wins_clr", sat_flag, 3'b001);
    tick();
    sat_clr = 1'b0;
    chk("t2_sat_cleared", sat_flag, 3'b000);

    // 3: rounding half toward +inf
    wr_gain(0, 24, 1'b1);
    in_valid = 1'b1; set_in(3, 0, 0);
    tick();
    set_in(-3, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("t3_3x1.5", $signed(band_out[0]), 5);
    tick();
    chk("t3_m3x1.5", $signed(band_out[0]), -4);
    wr_gain(0, 8, 1'b1);
    in_valid = 1'b1; set_in(1, 0, 0);
    tick();
    set_in(-1, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("t3_1x0.5", $signed(band_out[0]), 1);
    tick();
    chk("t3_m1x0.5", $signed(band_out[0]), 0);
    chk("t3_no_sat", sat_flag, 3'b000);

    // 4: ramp 16 -> 20 at one LSB per accepted sample
    wr_gain(0, 16, 1'b1);
    wr_gain(0, 20, 1'b0);
    chk("t4_rd_pending", ramp_done, 3'b110);
    set_in(160, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      in_valid = (n <= 6);
      tick();
      chk($sformatf("t4_rd_n%0d", n), ramp_done[0], (n >= 4) ? 1 : 0);
      chk($sformatf("t4_ov_n%0d", n), out_valid, (n >= 2 && n <= 7) ? 1 : 0);
      if (n >= 2 && n <= 7)
        chk($sformatf("t4_out_n%0d", n), $signed(band_out[0]), exp4[n-2]);
    end
    in_valid = 1'b0;

    // 5: same ramp with gapped valids
    wr_gain(0, 16, 1'b1);
    wr_gain(0, 20, 1'b0);
    for (int n = 1; n <= 13; n++) begin
      in_valid = (n % 2 == 1) && (n <= 11);
      tick();
      chk($sformatf("t5_ov_n%0d", n), out_valid, (n % 2 == 0 && n <= 12) ? 1 : 0);
      chk($sformatf("t5_out_n%0d", n), $signed(band_out[0]), exp5[n-1]);
      chk($sformatf("t5_rd_n%0d", n), ramp_done[0], (n >= 7) ? 1 : 0);
    end
    in_valid = 1'b0;

    // out-of-range select is ignored
    wr_gain(3, 50, 1'b1);
    chk("sel_oob_rd", ramp_done, 3'b111);
    in_valid = 1'b1; set_in(160, 7, 100);
    tick();
    in_valid = 1'b0;
    tick();
    chk("sel_oob_b0", $signed(band_out[0]), 200);
    chk("sel_oob_b1", $signed(band_out[1]), 7);
    chk("sel_oob_b2", $signed(band_out[2]), 100);

    // 6: reset mid-ramp with samples in flight
    wr_gain(0, 40, 1'b0);
    in_valid = 1'b1; set_in(160, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_ov_drop", out_valid, 0);
    chk("t6_out_clr", $signed(band_out[0]), 0);
    chk("t6_rd_reset", ramp_done, 3'b111);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_no_stale_ov", out_valid, 0);
    tick();
    chk("t6_no_stale_ov2", out_valid, 0);
    in_valid = 1'b1; set_in(160, 7, -5);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_ov", out_valid, 1);
    chk("t6_b0_unity", $signed(band_out[0]), 160);
    chk("t6_b1_unity", $signed(band_out[1]), 7);
    chk("t6_b2_unity", $signed(band_out[2]), -5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
